// File: rtl/xorshift_stream.sv
// ---------------------------------------------------------------------------
// xorshift_stream
//
// Parametrised xorshift pseudo-random generator. It presents its output as a
// valid/ready stream and accepts a new seed at runtime. After reset, or after
// a seed is loaded, it can discard a configurable number of states (warm-up)
// before it offers words to the consumer.
//
// Optional build macro:
//   XORSHIFT_PLUS_EN - out_data becomes state + previous state (xorshift+
//                      style output). Handshake, FSM and timing are identical
//                      in both builds.
//
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous, active-low reset
//   seed_valid  in   seed load request
//   seed        in   seed value (zero is replaced by RESET_SEED)
//   seed_ready  out  seed is accepted when seed_valid && seed_ready
//   out_valid   out  out_data holds a valid random word
//   out_ready   in   consumer accepts out_data
//   out_data    out  random word (combinational from the state register)
//   busy        out  high while warm-up states are being discarded
// ---------------------------------------------------------------------------
module xorshift_stream #(
  parameter int                 WIDTH        = 16,
  parameter int                 SHIFT_A      = 7,
  parameter int                 SHIFT_B      = 9,
  parameter int                 SHIFT_C      = 8,
  parameter logic [WIDTH-1:0]   RESET_SEED   = WIDTH'(1),
  parameter int                 WARMUP_STEPS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  output logic             seed_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } fsm_t;

  localparam logic [15:0] WARMUP_INIT = 16'(WARMUP_STEPS);
  localparam fsm_t        FSM_INIT    = (WARMUP_STEPS > 0) ? WARMUP : RUN;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             advance;
  logic             load;
  logic [WIDTH-1:0] load_value;
`ifdef XORSHIFT_PLUS_EN
  logic [WIDTH-1:0] prev_q, prev_d;
`endif

  // One xorshift step. The step is a bijection on nonzero values, so a
  // nonzero state can never become zero.
  function automatic logic [WIDTH-1:0] xs_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    s0 = s ^ (s << SHIFT_A);
    s1 = s0 ^ (s0 >> SHIFT_B);
    return s1 ^ (s1 << SHIFT_C);
  endfunction

  // A zero seed would lock the generator at zero, so it is replaced.
  assign load_value = (seed == '0) ? RESET_SEED : seed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= FSM_INIT;
      state_q <= RESET_SEED;
      cnt_q   <= WARMUP_INIT;
`ifdef XORSHIFT_PLUS_EN
      prev_q  <= '0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef XORSHIFT_PLUS_EN
      prev_q  <= prev_d;
`endif
    end
  end

  // Next-state and outputs. A seed request in RUN takes priority over a
  // simultaneous output handshake: the presented word counts as consumed,
  // but the state is replaced by the seed rather than advanced.
  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    out_valid  = 1'b0;
    seed_ready = 1'b0;
    busy       = 1'b0;
    advance    = 1'b0;
    load       = 1'b0;

    case (fsm_q)
      WARMUP: begin
        busy    = 1'b1;
        advance = 1'b1;
        cnt_d   = cnt_q - 16'd1;
        // The <= guard also rescues a counter that is somehow already zero.
        if (cnt_q <= 16'd1) begin
          fsm_d = RUN;
        end
      end
      RUN: begin
        out_valid  = 1'b1;
        seed_ready = 1'b1;
        if (seed_valid) begin
          load  = 1'b1;
          cnt_d = WARMUP_INIT;
          fsm_d = FSM_INIT;
        end else if (out_ready) begin
          advance = 1'b1;
        end
      end
      default: begin
        fsm_d = RUN;
      end
    endcase

    state_d = state_q;
    if (load) begin
      state_d = load_value;
    end else if (advance) begin
      state_d = xs_step(state_q);
    end

`ifdef XORSHIFT_PLUS_EN
    prev_d = prev_q;
    if (load) begin
      prev_d = '0;
    end else if (advance) begin
      prev_d = state_q;
    end
`endif
  end

`ifdef XORSHIFT_PLUS_EN
  assign out_data = state_q + prev_q;
`else
  assign out_data = state_q;
`endif

endmodule

// File: doc/xorshift_stream.md
Name: xorshift_stream

Overview:
- Parametrised xorshift pseudo-random generator with a valid/ready output stream and runtime seed loading.
- Configurable warm-up phase discards the first N states after reset or reseed.
- Feeds pattern, noise and dither logic in the display pipeline; it replaces fixed-width, enable-only generators.
- Each consumer instantiates its own copy with distinct shift constants and seed.

Parameters:
- WIDTH, 16, state and output width in bits; legal values 16 or 32.
- SHIFT_A, 7, left shift of step 1; 1..WIDTH-1.
- SHIFT_B, 9, right shift of step 2; 1..WIDTH-1.
- SHIFT_C, 8, left shift of step 3; 1..WIDTH-1.
- RESET_SEED, 1, state loaded at reset and substituted for a zero seed; WIDTH bits, must be nonzero.
- WARMUP_STEPS, 0, number of state advances discarded after reset or seed load; 0..65535.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- seed_valid  in  1  seed load request.
- seed  in  WIDTH  seed value.
- seed_ready  out  1  seed accepted when seed_valid && seed_ready.
- out_valid  out  1  out_data holds a valid random word.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WIDTH  random word.
- busy  out  1  high while in WARMUP.

Behaviour:
- Step function, all arithmetic truncated to WIDTH bits:
  - s0 = s ^ (s << SHIFT_A)
  - s1 = s0 ^ (s1 input s0 >> SHIFT_B), i.e. s1 = s0 ^ (s0 >> SHIFT_B)
  - next = s1 ^ (s1 << SHIFT_C)
- Shifts are logical and zero-filled. The nonzero-state invariant must always hold; a zero state is unreachable.
- FSM states:
  - WARMUP: state advances on every clk edge; warm-up counter decrements.
  - RUN: state advances only on a handshake.
- Reset (rst_n=0 at a clk edge):
  - state = RESET_SEED.
  - Counter = WARMUP_STEPS.
  - FSM = WARMUP if WARMUP_STEPS>0, else RUN.
  - out_valid=0 if WARMUP_STEPS>0, else 1; busy mirrors WARMUP; seed_ready=0 if WARMUP_STEPS>0, else 1.
- WARMUP:
  - out_valid=0, seed_ready=0, busy=1.
  - Each edge: state=next, counter-=1.
  - On the edge where counter goes 1->0, FSM=RUN. Exactly WARMUP_STEPS advances occur, and out_valid is high from the following cycle.
  - seed_valid is ignored (not accepted) during WARMUP.
- RUN:
  - out_valid=1, seed_ready=1, busy=0.
  - out_data = state, combinational from the state register, so zero latency.
  - out_valid && out_ready: state=next on that edge.
  - out_ready low: out_data is held stable indefinitely.
- Seed load in RUN:
  - seed_valid=1 loads state = seed, or RESET_SEED if seed==0.
  - Counter reloads to WARMUP_STEPS; FSM = WARMUP if WARMUP_STEPS>0, else stays in RUN.
- Simultaneous seed_valid and out_ready handshake:
  - Seed wins; the current out_data is counted as consumed.
  - Next cycle shows the seed (WARMUP_STEPS=0) or out_valid=0 (warm-up).
- Reset mid-warm-up or mid-stream aborts everything and restarts exactly as after power-up reset.
- Period: 2^WIDTH-1 for full-period shift triplets. Parameter choice is the integrator's responsibility; no runtime checking.

Optional Feature:
- Macro: XORSHIFT_PLUS_EN.
- Defined:
  - Adds register prev (WIDTH bits), reset to 0 and cleared to 0 on seed load.
  - On every state advance (warm-up or handshake), prev = old state.
  - out_data = state + prev mod 2^WIDTH, still combinational.
- Undefined:
  - No prev register; out_data = state.
  - Handshake, FSM and timing are identical in both builds.

Test Plan:
- Defaults (WIDTH=16, 7/9/8, seed 1, no warm-up), out_ready=1 after reset -> out_valid=1 on first cycle; out_data sequence 0x0001, 0x8181, 0x6021. With XORSHIFT_PLUS_EN: 0x0001, 0x8182, 0xE1A2.
- out_ready toggling 1,0,0,1 -> out_data is held across the low cycles; sequence is unchanged, with no skipped or duplicated words.
- WARMUP_STEPS=2, reset released -> busy=1 and out_valid=0 for exactly 2 cycles; first valid out_data=0x6021; seed_valid pulsed during warm-up -> seed_ready=0 and the seed is not loaded.
- In RUN, seed_valid=1 with seed=0x0000 together with out_ready=1 -> state=0x0001 (substitution wins over advance); next out_data=0x0001 (WARMUP_STEPS=0).
- Seed 0x1234 load, then rst_n low for one edge mid-stream -> out_data returns to 0x0001; FSM restarts per reset rules.
- WIDTH=32, SHIFT 13/17/5, seed 1 -> out_data 0x00000001, then 0x00042021, then matches the reference model for 1000 handshakes; no zero value is ever produced.
